dest_control: RTL

- Destination-domain half of the four-phase req/ack handshake CDC.
- Synchronizes the incoming request level and captures the source data bus once the request is stable.
- Presents captured data to the local consumer with valid/ready, returns ack, and completes the four-phase return-to-zero.
- Sits directly downstream of the source-side control; its ack_out crosses back to the source domain.

---
 rtl/cdc_hs_pkg.sv | 22 ++
 rtl/cdc_sync_bit.sv | 24 ++
 rtl/dest_control.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cdc_hs_pkg.sv
// Shared types and limits for the four-phase req/ack CDC handshake.
// Holds the handshake FSM state encoding, default widths and sync-depth bounds.
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } hs_state_e;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;

    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

    function automatic bit sync_stages_ok(input int n);
        return (n >= SYNC_MIN) && (n <= SYNC_MAX);
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// N-flop single-bit level synchronizer with async active-low reset to 0.
// Ports: clk_i, rst_ni, d_i (async level in), q_o (synchronized level out).
module cdc_sync_bit #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/dest_control.sv
// Destination half of a four-phase req/ack CDC: syncs req, captures data,
// hands it out on valid/ready, returns ack and counts completed transfers.
// Ports: clk_d, rst_n, req_in, data_in, data_ready -> ack_out, data_out,
//        data_valid, busy, proto_err, xfer_count.
module dest_control
    import cdc_hs_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk_d,
    input  logic              rst_n,
    input  logic              req_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_ready,
    output logic              ack_out,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              proto_err,
    output logic [CNT_W-1:0]  xfer_count
);

    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync
        $error("dest_control: SYNC_STAGES out of range");
    end

    logic req_sync;

    cdc_sync_bit #(
        .N (SYNC_STAGES)
    ) u_req_sync (
        .clk_i  (clk_d),
        .rst_ni (rst_n),
        .d_i    (req_in),
        .q_o    (req_sync)
    );

    hs_state_e         state_q, state_d;
    logic              ack_q, ack_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic hs_fire;
    assign hs_fire = valid_q && data_ready;

    // State and datapath registers
    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_sync) state_d = HOLD;
            HOLD: if (hs_fire)  state_d = ACK;
            ACK:  if (!req_sync) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        ack_d   = ack_q;
        valid_d = valid_q;
        err_d   = err_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                // data_in is stable once req_sync is seen high
                if (req_sync) begin
                    data_d  = data_in;
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                // Early req drop is flagged, delivery still proceeds
                if (!req_sync) err_d = 1'b1;
                if (hs_fire) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                end
            end
            ACK: begin
                if (!req_sync) begin
                    ack_d = 1'b0;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                ack_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Outputs
    assign ack_out    = ack_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign proto_err  = err_q;
    assign xfer_count = cnt_q;
    assign busy       = (state_q != IDLE);

endmodule
